maxpool2: RTL and testbench

MAXPOOL2 -- requirements
Module: maxpool2

---
 rtl/maxpool2_pkg.sv | 9 +
 rtl/maxpool2_maxwindow.sv | 14 +
 rtl/maxpool2.sv | 72 +++++++
 tb/tb_maxpool2.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/maxpool2_pkg.sv
// maxpool2_pkg: shared FSM state type, default pooling constants and index-width helper
package maxpool2_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, REDUCE, WRITE, FINISH} state_t;
  localparam int POOL_DEF = 2;
  localparam int WIDTH_BIT_DEF = 16;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/maxpool2_maxwindow.sv
// maxWindow: combinational signed maximum of a flattened POOL x POOL window
module maxWindow import maxpool2_pkg::*; #(
  parameter int POOL = POOL_DEF,
  parameter int WIDTH_BIT = WIDTH_BIT_DEF
) (
  input  logic [POOL*POOL*WIDTH_BIT-1:0] i_win,
  output logic signed [WIDTH_BIT-1:0]    o_max
);
  always_comb begin
    o_max = i_win[WIDTH_BIT-1:0];
    for (int i = 1; i < POOL*POOL; i++)
      o_max = ($signed(i_win[i*WIDTH_BIT +: WIDTH_BIT]) > o_max) ? i_win[i*WIDTH_BIT +: WIDTH_BIT] : o_max;
  end
endmodule

// File: rtl/maxpool2.sv
// maxpool2: FSM-sequenced POOL x POOL signed max pooling of a SIZE x SIZE matrix, one output per 3 cycles
module maxpool2 import maxpool2_pkg::*; #(
  parameter int SIZE = 318,
  parameter int POOL = POOL_DEF,
  parameter int WIDTH_BIT = WIDTH_BIT_DEF,
  localparam int OUTSZ = SIZE / POOL
) (
  input  logic                        clock,
  input  logic                        nreset,
  input  logic signed [WIDTH_BIT-1:0] inpMatrix [SIZE-1:0][SIZE-1:0],
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic signed [WIDTH_BIT-1:0] poolOut [OUTSZ-1:0][OUTSZ-1:0]
);
  localparam int IW = idx_w(SIZE);
  localparam int OW = idx_w(OUTSZ);
  localparam logic [WIDTH_BIT-1:0] LAST = WIDTH_BIT'(OUTSZ - 1);
  localparam logic [WIDTH_BIT-1:0] ONE = WIDTH_BIT'(1);
  state_t r_state, w_next;
  logic [WIDTH_BIT-1:0] r_row, r_col;
  logic [POOL*POOL*WIDTH_BIT-1:0] r_win;
  logic signed [WIDTH_BIT-1:0] r_max, w_max;
  logic w_last;
  assign w_last = (r_row == LAST) && (r_col == LAST);
  maxWindow #(.POOL(POOL), .WIDTH_BIT(WIDTH_BIT)) u_max (.i_win(r_win), .o_max(w_max));
  always_ff @(posedge clock or posedge nreset)
    if (nreset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    busy = (r_state != IDLE) && (r_state != FINISH);
    done = r_state == FINISH;
    case (r_state)
      IDLE:    if (start) w_next = LOAD;
      LOAD:    w_next = REDUCE;
      REDUCE:  w_next = WRITE;
      WRITE:   w_next = w_last ? FINISH : LOAD;
      default: w_next = IDLE;
    endcase
  end
  // Window indices never exceed OUTSZ*POOL-1, so an odd trailing row/column is never read
  always_ff @(posedge clock or posedge nreset)
    if (nreset) begin
      r_row <= '0;
      r_col <= '0;
      r_win <= '0;
      r_max <= '0;
      for (int r = 0; r < OUTSZ; r++)
        for (int c = 0; c < OUTSZ; c++)
          poolOut[r][c] <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_row <= '0;
          r_col <= '0;
        end
        LOAD:
          for (int k = 0; k < POOL; k++)
            for (int l = 0; l < POOL; l++)
              r_win[(k*POOL+l)*WIDTH_BIT +: WIDTH_BIT] <=
                inpMatrix[IW'(int'(r_row)*POOL + k)][IW'(int'(r_col)*POOL + l)];
        REDUCE: r_max <= w_max;
        WRITE: begin
          poolOut[OW'(r_row)][OW'(r_col)] <= r_max;
          r_col <= (r_col == LAST) ? '0 : r_col + ONE;
          r_row <= (r_col == LAST) ? r_row + ONE : r_row;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_maxpool2.sv
// tb_maxpool2: randomized scoreboard bench for maxpool2; SIZE=5 so the trailing row/column must be ignored
module tb_maxpool2;
  localparam int SIZE = 5, POOL = 2, W = 16, OUTSZ = 2, LAT = 3*OUTSZ*OUTSZ + 1;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done;
  logic signed [W-1:0] mat [SIZE-1:0][SIZE-1:0];
  logic signed [W-1:0] pout [OUTSZ-1:0][OUTSZ-1:0];
  int cyc = 0, checks = 0, errors = 0;
  int q_cyc[$];
  logic [OUTSZ*OUTSZ*W-1:0] q_val[$];

  maxpool2 #(.SIZE(SIZE), .POOL(POOL), .WIDTH_BIT(W)) dut (
    .clock(clk), .nreset(rst), .inpMatrix(mat), .start(start),
    .busy(busy), .done(done), .poolOut(pout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [OUTSZ*OUTSZ*W-1:0] model();
    logic [OUTSZ*OUTSZ*W-1:0] v;
    v = '0;
    for (int r = 0; r < OUTSZ; r++)
      for (int c = 0; c < OUTSZ; c++) begin
        int m;
        m = mat[POOL*r][POOL*c];
        for (int k = 0; k < POOL; k++)
          for (int l = 0; l < POOL; l++)
            if (mat[POOL*r+k][POOL*c+l] > m) m = mat[POOL*r+k][POOL*c+l];
        v[(r*OUTSZ+c)*W +: W] = W'(m);
      end
    return v;
  endfunction

  always @(negedge clk)
    if (done) begin
      if (q_cyc.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected at cycle %0d: got done=1 expected no outstanding run", cyc);
      end else begin
        int ec;
        logic [OUTSZ*OUTSZ*W-1:0] ev;
        ec = q_cyc.pop_front();
        ev = q_val.pop_front();
        chk("done_cycle", cyc, ec);
        chk("busy_in_finish", int'(busy), 0);
        for (int r = 0; r < OUTSZ; r++)
          for (int c = 0; c < OUTSZ; c++)
            chk($sformatf("pool[%0d][%0d]", r, c), int'(pout[r][c]), int'($signed(ev[(r*OUTSZ+c)*W +: W])));
      end
    end

  task automatic fill_rand();
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        mat[i][j] = W'($urandom);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    for (int r = 0; r < OUTSZ; r++)
      for (int c = 0; c < OUTSZ; c++)
        chk($sformatf("%s_pool[%0d][%0d]", tag, r, c), int'(pout[r][c]), 0);
  endtask

  task automatic run();
    q_cyc.push_back(cyc + LAT);
    q_val.push_back(model());
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (LAT) @(negedge clk);
  endtask

  initial begin
    int s, ph;
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        mat[i][j] = '0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        mat[i][j] = (i < 4 && j < 4) ? W'(i*4 + j + 1) : W'(1000);
    run();
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        mat[i][j] = (i < 4 && j < 4) ? W'(-5) : W'(7);
    mat[3][0] = W'(-1);
    run();
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        mat[i][j] = '0;
    mat[4][4] = W'(100);
    run();
    repeat (8) begin
      fill_rand();
      run();
    end
    fill_rand();
    q_cyc.push_back(cyc + LAT);
    q_val.push_back(model());
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (LAT - 5) @(negedge clk);
    repeat (3) @(negedge clk);
    fill_rand();
    run();
    fill_rand();
    s = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check_cleared("abort");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (s + 14 - cyc) @(negedge clk);
    check_cleared("after_abort");
    fill_rand();
    run();
    fill_rand();
    s = cyc;
    for (int n = 0; n < 3; n++) begin
      q_cyc.push_back(s + LAT + n*(LAT + 1));
      q_val.push_back(model());
    end
    start = 1'b1;
    for (int i = 1; i <= 3*(LAT + 1); i++) begin
      @(negedge clk);
      if (i == 2*(LAT + 1) + 2) start = 1'b0;
      ph = (cyc - s) % (LAT + 1);
      chk("busy_held", int'(busy), int'(ph != 0 && ph != LAT));
    end
    repeat (5) @(negedge clk);
    chk("queue_drained", q_cyc.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
